fetch_stage: RTL and testbench

Instruction-fetch stage, directly upstream of the decode stage. It owns the fetch PC and issues in-order requests to instruction memory over a valid/ready handshake. Returned instructions are buffered with their PC in a small in-order queue and presented to decode as `{instr, pc, pc+4, vld}`. On a redirect from decode (JAL) or execute (branch/JALR), the queue is flushed, the PC is retargeted, and responses to requests already in flight are discarded.

---
 rtl/core_types_pkg.sv | 12 +
 rtl/riscv_pkg.sv | 7 +
 rtl/fetch_queue.sv | 82 ++++++++
 rtl/fetch_stage.sv | 132 +++++++++++++
 tb/tb_fetch_stage.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_types_pkg.sv
// Payload types passed between pipeline structures of the core.
package core_types_pkg;

    import riscv_pkg::*;

    typedef struct packed {
        logic [N_BITS-1:0] pc;
        logic [N_BITS-1:0] instr;
        logic              filled;
    } fetch_entry_t;

endpackage

// File: rtl/riscv_pkg.sv
// ISA-level constants shared by the front end.
package riscv_pkg;

    localparam int unsigned N_BITS      = 32;
    localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_queue.sv
// In-order circular buffer of fetched instructions with separate alloc/fill/head pointers.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fetch_queue
    import riscv_pkg::*;
    import core_types_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_alloc,
    input  logic [N_BITS-1:0]      i_alloc_pc,
    input  logic                   i_fill,
    input  logic [N_BITS-1:0]      i_fill_instr,
    input  logic                   i_deq,
    input  logic                   i_flush,
    output logic [$clog2(DEPTH):0] o_occupancy,
    output logic [$clog2(DEPTH):0] o_unfilled,
    output logic                   o_head_vld,
    output logic [N_BITS-1:0]      o_head_pc,
    output logic [N_BITS-1:0]      o_head_instr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_alloc;
    logic [PW-1:0] r_fill;

    logic [AW-1:0] w_head_idx;
    logic [AW-1:0] w_alloc_idx;
    logic [AW-1:0] w_fill_idx;
    fetch_entry_t  w_head;

    assign w_head_idx  = r_head[AW-1:0];
    assign w_alloc_idx = r_alloc[AW-1:0];
    assign w_fill_idx  = r_fill[AW-1:0];
    assign w_head      = r_mem[w_head_idx];

    assign o_occupancy  = r_alloc - r_head;
    assign o_unfilled   = r_alloc - r_fill;
    assign o_head_vld   = (o_occupancy != '0) && w_head.filled;
    assign o_head_pc    = o_head_vld ? w_head.pc    : '0;
    assign o_head_instr = o_head_vld ? w_head.instr : '0;

    // Flush discards every entry by collapsing head and fill onto alloc.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_alloc <= '0;
            r_fill  <= '0;
        end else if (i_flush) begin
            r_head <= r_alloc;
            r_fill <= r_alloc;
        end else begin
            if (i_alloc) begin
                r_alloc <= r_alloc + PW'(1);
            end
            if (i_fill) begin
                r_fill <= r_fill + PW'(1);
            end
            if (i_deq) begin
                r_head <= r_head + PW'(1);
            end
        end
    end

    // Alloc always targets a free slot and fill an occupied one, so they never collide.
    always_ff @(posedge clk) begin
        if (i_alloc && !i_flush) begin
            r_mem[w_alloc_idx].pc     <= i_alloc_pc;
            r_mem[w_alloc_idx].filled <= 1'b0;
        end
        if (i_fill && !i_flush) begin
            r_mem[w_fill_idx].instr  <= i_fill_instr;
            r_mem[w_fill_idx].filled <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem request issue, in-flight drop accounting and redirect handling.
// Optional FETCH_PERF_CNT_EN adds bubble/redirect performance counters.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [N_BITS-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned       DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_vld,
    input  logic              imem_req_rdy,
    output logic [N_BITS-1:0] imem_req_addr,
    input  logic              imem_rsp_vld,
    input  logic [N_BITS-1:0] imem_rsp_data,
    input  logic              D_redirect_vld,
    input  logic [N_BITS-1:0] D_redirect_tgt,
    input  logic              X_redirect_vld,
    input  logic [N_BITS-1:0] X_redirect_tgt,
    input  logic              stall_in,
    output logic [N_BITS-1:0] instr_out,
    output logic [N_BITS-1:0] pc_out,
    output logic [N_BITS-1:0] pc_plus4_out,
    output logic              vld_out
`ifdef FETCH_PERF_CNT_EN
   ,output logic [31:0]       perf_bubble_cnt
   ,output logic [31:0]       perf_redirect_cnt
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    logic [N_BITS-1:0] r_pc;
    logic [CW-1:0]     r_drop;
    logic              r_run;

    logic              w_redirect;
    logic [N_BITS-1:0] w_tgt;
    logic [CW-1:0]     w_occ;
    logic [CW-1:0]     w_unfilled;
    logic [SW-1:0]     w_inflight;
    logic              w_alloc;
    logic              w_rsp_drop;
    logic              w_rsp_live;
    logic              w_fill;
    logic              w_deq;
    logic              w_head_vld;
    logic [N_BITS-1:0] w_head_pc;
    logic [N_BITS-1:0] w_head_instr;
    logic [CW-1:0]     w_drop_nxt;

    assign w_redirect = X_redirect_vld || D_redirect_vld;
    assign w_tgt      = X_redirect_vld ? X_redirect_tgt : D_redirect_tgt;

    // Every queue slot or owed response counts against the in-flight budget.
    assign w_inflight    = SW'(w_occ) + SW'(r_drop);
    assign imem_req_vld  = r_run && !w_redirect && (w_inflight < SW'(DEPTH));
    assign imem_req_addr = r_pc;
    assign w_alloc       = imem_req_vld && imem_req_rdy;

    assign w_rsp_drop = imem_rsp_vld && (r_drop != '0);
    assign w_rsp_live = imem_rsp_vld && (r_drop == '0) && (w_unfilled != '0);
    assign w_fill     = w_rsp_live && !w_redirect;

    assign vld_out      = w_head_vld && !w_redirect;
    assign w_deq        = vld_out && !stall_in;
    assign instr_out    = w_head_instr;
    assign pc_out       = w_head_pc;
    assign pc_plus4_out = w_head_vld ? (w_head_pc + N_BITS'(INSTR_BYTES)) : '0;

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_alloc      (w_alloc),
        .i_alloc_pc   (r_pc),
        .i_fill       (w_fill),
        .i_fill_instr (imem_rsp_data),
        .i_deq        (w_deq),
        .i_flush      (w_redirect),
        .o_occupancy  (w_occ),
        .o_unfilled   (w_unfilled),
        .o_head_vld   (w_head_vld),
        .o_head_pc    (w_head_pc),
        .o_head_instr (w_head_instr)
    );

    // On redirect, unfilled entries become owed drops; a response landing now is also discarded.
    always_comb begin
        w_drop_nxt = r_drop;
        if (w_redirect) begin
            w_drop_nxt = r_drop + w_unfilled - CW'(w_rsp_drop || w_rsp_live);
        end else if (w_rsp_drop) begin
            w_drop_nxt = r_drop - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc   <= RESET_PC;
            r_drop <= '0;
            r_run  <= 1'b0;
        end else begin
            r_run  <= 1'b1;
            r_drop <= w_drop_nxt;
            if (w_redirect) begin
                r_pc <= w_tgt;
            end else if (w_alloc) begin
                r_pc <= r_pc + N_BITS'(INSTR_BYTES);
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_bubble_cnt   <= '0;
            perf_redirect_cnt <= '0;
        end else begin
            if (!vld_out && !stall_in) begin
                perf_bubble_cnt <= perf_bubble_cnt + 32'(1);
            end
            if (w_redirect) begin
                perf_redirect_cnt <= perf_redirect_cnt + 32'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a queue-based model of the fetch/decode stream.
module tb_fetch_stage;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_vld;
    logic        imem_req_rdy = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_vld = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        D_redirect_vld = 1'b0;
    logic [31:0] D_redirect_tgt = 32'h0;
    logic        X_redirect_vld = 1'b0;
    logic [31:0] X_redirect_tgt = 32'h0;
    logic        stall_in = 1'b0;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;
    logic        vld_out;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_bubble_cnt;
    logic [31:0] perf_redirect_cnt;
`endif

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_vld   (imem_req_vld),
        .imem_req_rdy   (imem_req_rdy),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_vld   (imem_rsp_vld),
        .imem_rsp_data  (imem_rsp_data),
        .D_redirect_vld (D_redirect_vld),
        .D_redirect_tgt (D_redirect_tgt),
        .X_redirect_vld (X_redirect_vld),
        .X_redirect_tgt (X_redirect_tgt),
        .stall_in       (stall_in),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .pc_plus4_out   (pc_plus4_out),
        .vld_out        (vld_out)
`ifdef FETCH_PERF_CNT_EN
       ,.perf_bubble_cnt   (perf_bubble_cnt)
       ,.perf_redirect_cnt (perf_redirect_cnt)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          ready;
    } mreq_t;

    mreq_t       memq[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    logic        c_rst_n = 1'b0;
    logic        c_rdy = 1'b1;
    logic        c_stall = 1'b0;
    logic        c_dv = 1'b0;
    logic        c_xv = 1'b0;
    logic [31:0] c_dt = 32'h0;
    logic [31:0] c_xt = 32'h0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          last_ready = 0;

    logic [31:0] m_fetch_pc = RESET_PC;
    logic [31:0] m_dec_pc = RESET_PC;
    int          m_buf = 0;
    int          m_epoch = 0;
    bit          m_started = 1'b0;
    bit          rsp_now = 1'b0;
    int          m_bub = 0;
    int          m_red = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5EED_C0DE;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: outstanding responses in memq, filled-but-undelivered instructions in m_buf.
    task automatic model_cycle();
        logic        redirect;
        logic [31:0] tgt;
        bit          exp_vld;
        bit          exp_req;
        bit          live;
        mreq_t       e;
        int          r;
        if (!rst_n) begin
            memq.delete();
            m_fetch_pc = RESET_PC;
            m_dec_pc   = RESET_PC;
            m_buf      = 0;
            m_started  = 1'b0;
            last_ready = 0;
            m_bub      = 0;
            m_red      = 0;
            return;
        end
        redirect = c_dv || c_xv;
        tgt      = c_xv ? c_xt : c_dt;
        exp_vld  = (m_buf > 0) && !redirect;
        exp_req  = m_started && !redirect && ((memq.size() + m_buf) < int'(DEPTH));

        chk("vld_out", 32'(vld_out), 32'(exp_vld));
        chk("req_vld", 32'(imem_req_vld), 32'(exp_req));
        chk("req_addr", imem_req_addr, m_fetch_pc);
        if (exp_vld) begin
            chk("pc_out", pc_out, m_dec_pc);
            chk("instr_out", instr_out, mem_word(m_dec_pc));
            chk("pc_plus4_out", pc_plus4_out, m_dec_pc + 32'd4);
        end

        if (!exp_vld && !c_stall) m_bub++;
        if (redirect) m_red++;

        live = 1'b0;
        if (rsp_now) begin
            e    = memq.pop_front();
            live = (e.epoch == m_epoch) && !redirect;
        end
        if (redirect) begin
            m_buf      = 0;
            m_epoch++;
            m_fetch_pc = tgt;
            m_dec_pc   = tgt;
        end else begin
            if (exp_vld && !c_stall) begin
                m_buf--;
                m_dec_pc += 32'd4;
            end
            if (live) m_buf++;
            if (exp_req && c_rdy) begin
                r = cyc + int'($urandom_range(lat_max, lat_min));
                if (r <= last_ready) r = last_ready + 1;
                last_ready = r;
                memq.push_back('{m_fetch_pc, m_epoch, r});
                m_fetch_pc += 32'd4;
            end
        end
        m_started = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        rst_n         = c_rst_n;
        rsp_now       = rst_n && (memq.size() > 0) && (memq[0].ready <= cyc);
        imem_rsp_vld  = rsp_now;
        imem_rsp_data = rsp_now ? mem_word(memq[0].addr) : 32'h0;
        assert (!imem_rsp_vld || memq.size() > 0) else $error("response with nothing outstanding");
        imem_req_rdy   = c_rdy;
        stall_in       = c_stall;
        D_redirect_vld = c_dv;
        D_redirect_tgt = c_dt;
        X_redirect_vld = c_xv;
        X_redirect_tgt = c_xt;
        @(negedge clk);
        model_cycle();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_vld(input string name, input logic [31:0] exp_pc, input int budget);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!vld_out && k < budget);
        chk({name, "_seen"}, 32'(vld_out), 32'd1);
        chk({name, "_pc"}, pc_out, exp_pc);
    endtask

    task automatic do_reset();
        c_rst_n = 1'b0;
        c_dv    = 1'b0;
        c_xv    = 1'b0;
        c_stall = 1'b0;
        run(2);
        chk("rst_vld_out", 32'(vld_out), 32'd0);
        chk("rst_req_vld", 32'(imem_req_vld), 32'd0);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        chk("rst_pc_out", pc_out, 32'd0);
        chk("rst_instr_out", instr_out, 32'd0);
        chk("rst_pc_plus4_out", pc_plus4_out, 32'd0);
        c_rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_req;
        int first_vld;
        int r;

        // Streaming from reset with a 1-cycle always-ready memory.
        lat_min = 1; lat_max = 1; c_rdy = 1'b1;
        do_reset();
        first_req = -1;
        first_vld = -1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (first_req < 0 && imem_req_vld && imem_req_rdy) begin
                first_req = cyc;
                chk("first_req_addr", imem_req_addr, 32'h0);
            end
            if (first_vld < 0 && vld_out) begin
                first_vld = cyc;
                chk("first_pc", pc_out, 32'h0);
                chk("first_plus4", pc_plus4_out, 32'h4);
                chk("first_instr", instr_out, mem_word(32'h0));
            end
        end
        chk("first_latency", 32'(first_vld - first_req), 32'd2);

        // Five-cycle stall: queue fills and issue stops.
        c_stall = 1'b1;
        run(5);
        chk("stall_full_req", 32'(imem_req_vld), 32'd0);
        c_stall = 1'b0;
        run(10);

        // Execute redirect with several requests still in flight.
        lat_min = 3; lat_max = 3;
        run(6);
        c_xv = 1'b1; c_xt = 32'h0000_0100;
        step();
        c_xv = 1'b0;
        wait_vld("x_redir", 32'h0000_0100, 20);

        // Simultaneous decode and execute redirects: execute wins.
        lat_min = 1; lat_max = 1;
        run(4);
        c_dv = 1'b1; c_dt = 32'h0000_0200;
        c_xv = 1'b1; c_xt = 32'h0000_0300;
        step();
        c_dv = 1'b0; c_xv = 1'b0;
        step();
        chk("dx_addr", imem_req_addr, 32'h0000_0300);
        wait_vld("dx_prio", 32'h0000_0300, 20);

        // Address wrap at the top of the address space.
        run(3);
        c_xv = 1'b1; c_xt = 32'hFFFF_FFF8;
        step();
        c_xv = 1'b0;
        wait_vld("wrap_a", 32'hFFFF_FFF8, 20);
        wait_vld("wrap_b", 32'hFFFF_FFFC, 5);
        chk("wrap_plus4", pc_plus4_out, 32'h0);
        wait_vld("wrap_c", 32'h0000_0000, 5);

        // Randomized traffic: backpressure, variable latency, stalls, redirects.
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            c_rdy   = ($urandom_range(9, 0) < 7);
            c_stall = ($urandom_range(3, 0) == 0);
            r       = int'($urandom_range(99, 0));
            c_xv    = (r < 3);
            c_dv    = (r == 0) || (r >= 3 && r < 6);
            c_xt    = (r == 1) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
            c_dt    = $urandom & 32'hFFFF_FFFC;
            step();
        end

        // Drain: with drops settled, streaming resumes at full rate.
        c_rdy = 1'b1; c_stall = 1'b0; c_xv = 1'b0; c_dv = 1'b0;
        lat_min = 1; lat_max = 1;
        run(20);
        chk("drain_req_vld", 32'(imem_req_vld), 32'd1);
        chk("drain_vld_out", 32'(vld_out), 32'd1);

        // Reset in the middle of traffic with responses outstanding.
        lat_min = 3; lat_max = 3;
        run(5);
        do_reset();
        wait_vld("post_rst", RESET_PC, 12);
        run(10);

`ifdef FETCH_PERF_CNT_EN
        chk("perf_bubble", perf_bubble_cnt, 32'(m_bub));
        chk("perf_redirect", perf_redirect_cnt, 32'(m_red));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
